div_accel: RTL and testbench

Iterative 16-bit unsigned restoring divider. It is the responder side of the CPU divide-accelerator handshake: it accepts a start pulse with dividend and divisor from the CPU decode path, computes one quotient bit per cycle, and returns quotient, remainder and a one-cycle done pulse. The accelerator result-injection state machine consumes those results and writes them to memory. It sits beside the CPU core in the FPGA top level, on the same clock.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/div_step.sv | 31 +++
 rtl/div_accel.sv | 115 +++++++++++
 tb/tb_div_accel.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the divide accelerator.
package cpu_pkg;

  // Operand, quotient and remainder width of the divide accelerator.
  localparam int unsigned DIV_WIDTH = 16;

  // Divider FSM states. The S_DIV_ prefix keeps these literals apart from the
  // result-injection t_state literals that live in the same scope.
  typedef enum logic [1:0] {
    S_DIV_IDLE = 2'd0,
    S_DIV_RUN  = 2'd1,
    S_DIV_DONE = 2'd2
  } t_div_state;

  // Width of a down-counter that must hold the value 'width'.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {r,q} left, trial-subtract the divisor,
// keep the difference and set the new quotient bit when it does not go negative.
module div_step
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  // Shift is done in a WIDTH+2 frame so the subtraction sign lands in the MSB.
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  // Shift, trial subtract and restore/commit.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    trial   = r_shift - {2'b00, divisor};
    q_next  = {q[WIDTH-2:0], 1'b0};
    r_next  = r_shift[WIDTH:0];
    if (!trial[WIDTH+1]) begin
      r_next    = trial[WIDTH:0];
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_accel.sv
// Iterative unsigned restoring divider, responder side of the CPU divide
// handshake. One quotient bit per cycle; Done pulses for one cycle when the
// held Quotient/Remainder outputs become valid.
module div_accel
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv,
  input  logic [WIDTH-1:0] Divident,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             Busy
);

  localparam int unsigned CntW = div_cnt_width(WIDTH);

  t_div_state       state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (divisor_q),
    .r_next  (r_step),
    .q_next  (q_step)
  );

  // Next-state logic: accept a start in idle, iterate, then publish results.
  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    q_d       = q_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    unique case (state_q)
      S_DIV_IDLE: begin
        if (StartDiv) begin
          if (Divisor != '0) begin
            divisor_d = Divisor;
            q_d       = Divident;
            r_d       = '0;
            cnt_d     = CntW'(WIDTH);
            state_d   = S_DIV_RUN;
          end else begin
            // Divide by zero: all-ones quotient, dividend as remainder.
            quot_d  = '1;
            rem_d   = Divident;
            state_d = S_DIV_DONE;
          end
        end
      end
      S_DIV_RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quot_d  = q_step;
          rem_d   = r_step[WIDTH-1:0];
          state_d = S_DIV_DONE;
        end
      end
      S_DIV_DONE: begin
        state_d = S_DIV_IDLE;
      end
      default: begin
        state_d = S_DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_DIV_IDLE;
      divisor_q <= '0;
      q_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      q_q       <= q_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
    end
  end

  // Results are held between operations; the consumer reads them late.
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Done      = (state_q == S_DIV_DONE);
  assign Busy      = (state_q != S_DIV_IDLE);

endmodule

// File: tb/tb_div_accel.sv
// Self-checking bench for div_accel: directed cases plus back-to-back random
// operations, results checked through a scoreboard queue.
module tb_div_accel;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        StartDiv = 1'b0;
  logic [15:0] Divident = '0;
  logic [15:0] Divisor = '0;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        Done;
  logic        Busy;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];
  exp_t got;

  div_accel #(
    .WIDTH (16)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .StartDiv  (StartDiv),
    .Divident  (Divident),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Done      (Done),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard monitor: every Done pops one expected result.
  always @(negedge Clk) begin
    if (Reset) begin
      if (Done) begin
        n_done++;
        check_eq("done_pulse_width", {31'b0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_done", n_done, n_push);
        end else begin
          got = sb.pop_front();
          check_eq("quotient", {16'b0, Quotient}, {16'b0, got.q});
          check_eq("remainder", {16'b0, Remainder}, {16'b0, got.r});
        end
      end
      prev_done = Done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Called at a falling edge; StartDiv is high for cycle n only.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, output int n);
    StartDiv = 1'b1;
    Divident = a;
    Divisor  = b;
    n        = cyc;
    sb.push_back(model(a, b));
    n_push++;
    @(negedge Clk);
    StartDiv = 1'b0;
  endtask

  // Bounded wait for Done; at stays -1 on timeout so the latency check fails.
  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        at = cyc;
        break;
      end
      @(negedge Clk);
    end
  endtask

  // One operation at the minimum issue interval; returns one cycle after Done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    int n;
    int at;
    issue(a, b, n);
    check_eq("busy_after_start", {31'b0, Busy}, 32'd1);
    wait_done(at);
    check_eq("done_latency", at - n, (b == 16'd0) ? 32'd1 : 32'd17);
    @(negedge Clk);
    check_eq("busy_after_done", {31'b0, Busy}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   at;
    logic [15:0] a;
    logic [15:0] b;

    repeat (2) @(negedge Clk);
    check_eq("reset_quotient", {16'b0, Quotient}, 32'd0);
    check_eq("reset_remainder", {16'b0, Remainder}, 32'd0);
    check_eq("reset_done", {31'b0, Done}, 32'd0);
    check_eq("reset_busy", {31'b0, Busy}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // 20000 / 10 with results held through N+20.
    issue(16'd20000, 16'd10, n);
    wait_done(at);
    check_eq("latency_20000_10", at - n, 32'd17);
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      check_eq("hold_quotient", {16'b0, Quotient}, 32'd2000);
      check_eq("hold_remainder", {16'b0, Remainder}, 32'd0);
    end

    run_op(16'd65535, 16'd1);
    run_op(16'd7, 16'd9);
    run_op(16'd100, 16'd0);

    // A start pulse while running must be ignored.
    issue(16'd50000, 16'd7, n);
    repeat (4) @(negedge Clk);
    StartDiv = 1'b1;
    Divident = 16'd1;
    Divisor  = 16'd1;
    @(negedge Clk);
    StartDiv = 1'b0;
    wait_done(at);
    check_eq("latency_ignored_start", at - n, 32'd17);
    @(negedge Clk);

    // Reset mid-operation aborts it with no Done.
    issue(16'd1000, 16'd3, n);
    repeat (7) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_eq("abort_quotient", {16'b0, Quotient}, 32'd0);
    check_eq("abort_remainder", {16'b0, Remainder}, 32'd0);
    check_eq("abort_done", {31'b0, Done}, 32'd0);
    check_eq("abort_busy", {31'b0, Busy}, 32'd0);
    sb.delete();
    n_push--;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (25) @(negedge Clk);
    check_eq("no_done_after_abort", n_done, n_push);
    run_op(16'd9, 16'd2);

    // Random operands back-to-back, with zero, small and equal divisors mixed in.
    for (int i = 0; i < 2500; i++) begin
      a = 16'($urandom);
      case (i % 8)
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a;
        default: b = 16'($urandom);
      endcase
      run_op(a, b);
    end

    check_eq("done_count", n_done, n_push);
    check_eq("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
